// File: rtl/ray_pkg.sv
// Shared types for the frame reader: pixel word, reader FSM states, dimension width.
package ray_pkg;
  localparam int PIXEL_WIDTH = 24;
  localparam int DIM_WIDTH   = 12;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} reader_state_t;
endpackage

// File: rtl/frame_reader_if.sv
// Read-request bus plus raster pixel stream of the frame reader.
interface frame_reader_if #(
  parameter int DATA_WIDTH    = 24,
  parameter int ADDRESS_WIDTH = 32
);
  logic [ADDRESS_WIDTH-1:0] readAddress;
  logic                     readValid;
  logic                     readReady;
  logic [DATA_WIDTH-1:0]    readData;
  logic                     readDataValid;
  logic [DATA_WIDTH-1:0]    pixelData;
  logic                     pixelValid;
  logic                     pixelReady;
  logic                     pixelSof;
  logic                     pixelEol;
  logic                     pixelEof;

  modport master (
    output readAddress, readValid, pixelData, pixelValid, pixelSof, pixelEol, pixelEof,
    input  readReady, readData, readDataValid, pixelReady
  );
  modport slave (
    input  readAddress, readValid, pixelData, pixelValid, pixelSof, pixelEol, pixelEof,
    output readReady, readData, readDataValid, pixelReady
  );
endinterface

// File: rtl/pixel_fifo.sv
// Response buffer: synchronous FIFO with combinational head read and a clear that wins over push/pop.
module pixel_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        clear,
  input  logic [DATA_WIDTH-1:0]       data,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        empty,
  output logic                        full,
  output logic [DATA_WIDTH-1:0]       head
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= data;
  end
endmodule

// File: rtl/frame_reader.sv
// Reads a width*height frame from word-addressed memory and streams it in raster order.
// Define FRAME_READER_LOOP_EN to rerun the latched frame continuously until flush.
module frame_reader import ray_pkg::*; #(
  parameter int DATA_WIDTH    = 24,
  parameter int ADDRESS_WIDTH = 32,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     flush,
  input  logic [ADDRESS_WIDTH-1:0] frameAddress,
  input  logic [DIM_WIDTH-1:0]     width,
  input  logic [DIM_WIDTH-1:0]     height,
  output logic                     ready,
  output logic                     busy,
  output logic                     done,
  frame_reader_if.master           bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = 2 * DIM_WIDTH;

  reader_state_t            state, state_nx;
  logic [ADDRESS_WIDTH-1:0] base;
  logic [DIM_WIDTH-1:0]     w, h, x, y;
  logic [TW-1:0]            total, req_idx, req_next;
  logic [CW-1:0]            in_flight, fifo_count;
  logic [DATA_WIDTH-1:0]    head;
  logic fifo_empty, fifo_full, fifo_clear, fifo_push;
  logic start_ok, zero, accept, resp_dec, pop, last_x, last_y, eof_pop, more, credit;

  assign start_ok   = start && (state == IDLE);
  assign zero       = (width == '0) || (height == '0);
  assign accept     = bus.readValid && bus.readReady;
  assign pop        = bus.pixelValid && bus.pixelReady;
  assign resp_dec   = bus.readDataValid && (in_flight != '0);
  assign last_x     = (x == w - 1'b1);
  assign last_y     = (y == h - 1'b1);
  assign eof_pop    = pop && last_x && last_y && !flush;
  assign fifo_clear = ((state == FETCH) && flush) || start_ok;
  assign fifo_push  = bus.readDataValid && (state == FETCH) && !flush;

`ifdef FRAME_READER_LOOP_EN
  assign more     = 1'b1;
  assign req_next = (req_idx == total - 1'b1) ? '0 : req_idx + 1'b1;
`else
  assign more     = (req_idx < total);
  assign req_next = req_idx + 1'b1;
`endif

  // Outstanding reads plus buffered pixels never exceed the FIFO, so responses always fit.
  assign credit = ({1'b0, in_flight} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);

  assign bus.readValid   = (state == FETCH) && more && credit && !fifo_full;
  assign bus.readAddress = base + ADDRESS_WIDTH'(req_idx);
  assign bus.pixelValid  = (state == FETCH) && !fifo_empty;
  assign bus.pixelData   = head;
  assign bus.pixelSof    = (x == '0) && (y == '0);
  assign bus.pixelEol    = last_x;
  assign bus.pixelEof    = last_x && last_y;
  assign ready           = (state == IDLE);
  assign busy            = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start_ok && !zero) state_nx = FETCH;
`ifdef FRAME_READER_LOOP_EN
      FETCH: if (flush) state_nx = FLUSH;
`else
      FETCH: if (flush) state_nx = FLUSH;
             else if (eof_pop) state_nx = IDLE;
`endif
      FLUSH: if (in_flight == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      base      <= '0;
      w         <= '0;
      h         <= '0;
      total     <= '0;
      req_idx   <= '0;
      in_flight <= '0;
      x         <= '0;
      y         <= '0;
      done      <= 1'b0;
    end else begin
      done <= (start_ok && zero) || ((state == FETCH) && eof_pop);
      if (start_ok) begin
        base    <= frameAddress;
        w       <= width;
        h       <= height;
        total   <= TW'(width) * TW'(height);
        req_idx <= '0;
        x       <= '0;
        y       <= '0;
      end else begin
        if (accept) req_idx <= req_next;
        if (pop && !flush) begin
          x <= last_x ? '0 : x + 1'b1;
          if (last_x) y <= last_y ? '0 : y + 1'b1;
        end
      end
      if (accept && !resp_dec)      in_flight <= in_flight + 1'b1;
      else if (!accept && resp_dec) in_flight <= in_flight - 1'b1;
    end
  end

  pixel_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (pop),
    .clear (fifo_clear),
    .data  (bus.readData),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full),
    .head  (head)
  );
endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: frame table, flush, mid-frame reset, optional loop mode.
module tb_frame_reader;
  logic        clock = 1'b0;
  logic        reset, start, flush;
  logic [31:0] frameAddress;
  logic [11:0] width, height;
  logic        ready, busy, done;

  frame_reader_if #(.DATA_WIDTH(24), .ADDRESS_WIDTH(32)) bus ();

  frame_reader #(.DATA_WIDTH(24), .ADDRESS_WIDTH(32), .FIFO_DEPTH(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .flush        (flush),
    .frameAddress (frameAddress),
    .width        (width),
    .height       (height),
    .ready        (ready),
    .busy         (busy),
    .done         (done),
    .bus          (bus)
  );

  always #5 clock = ~clock;

  typedef struct { logic [23:0] data; logic sof, eol, eof; } pix_t;
  typedef struct { logic [11:0] w, h; logic [31:0] base; int hold; int exp_n; int exp_stall; } vec_t;

  pix_t        pix_q[$];
  logic [31:0] addr_q[$];
  int checks = 0, errors = 0;
  int acc_cnt = 0, pop_cnt = 0, done_cnt = 0, max_out = 0, rv_seen = 0, lat = 2;
  logic        pv[8];
  logic [31:0] pa[8];

  function automatic logic [23:0] memf(input logic [31:0] a);
    return a[23:0] ^ 24'h5A3C96;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int pending();
    int p = int'(bus.readDataValid);
    for (int i = 0; i < lat; i++) p += int'(pv[i]);
    return p;
  endfunction

  // Memory with fixed latency plus stream/handshake monitor, sampled between edges.
  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) pv[i] = 1'b0;
      bus.readDataValid = 1'b0;
    end else begin
      pix_t p;
      bus.readDataValid = pv[lat-1];
      bus.readData      = memf(pa[lat-1]);
      for (int i = 7; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
      pv[0] = bus.readValid && bus.readReady;
      pa[0] = bus.readAddress;
      if (pv[0]) begin acc_cnt++; addr_q.push_back(bus.readAddress); end
      if (bus.readValid) rv_seen = 1;
      if (bus.pixelValid && bus.pixelReady) begin
        pop_cnt++;
        p.data = bus.pixelData; p.sof = bus.pixelSof; p.eol = bus.pixelEol; p.eof = bus.pixelEof;
        pix_q.push_back(p);
      end
      if (done) done_cnt++;
      if (acc_cnt - pop_cnt > max_out) max_out = acc_cnt - pop_cnt;
    end
  end

  task automatic clr();
    acc_cnt = 0; pop_cnt = 0; done_cnt = 0; max_out = 0; rv_seen = 0;
    pix_q.delete(); addr_q.delete();
  endtask

  task automatic kick(input logic [11:0] w, input logic [11:0] h, input logic [31:0] b);
    @(posedge clock); #1;
    start = 1'b1; width = w; height = h; frameAddress = b;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int n, to, bad, bad_a;
    pix_t p;
    n = v.exp_n;
    clr();
    bus.pixelReady = (v.hold == 0);
    kick(v.w, v.h, v.base);
    @(negedge clock); #1;
    chk("done_after_start", done, n == 0);
    chk("rv_after_start", bus.readValid, n != 0);
    chk("busy_after_start", busy, n != 0);
    if (v.hold > 0) begin
      repeat (v.hold) @(posedge clock);
      #1;
      chk("stall_outstanding", max_out, v.exp_stall);
      chk("stall_rv_low", bus.readValid, 0);
      bus.pixelReady = 1'b1;
    end
    to = 0;
    while (done_cnt == 0 && to < 3000) begin @(negedge clock); #1; to++; end
    repeat (3) @(negedge clock);
    #1;
    chk("done_count", done_cnt, 1);
    chk("ready_after", ready, 1);
    chk("busy_after", busy, 0);
    chk("rv_seen", rv_seen, n != 0);
    chk("acc_count", acc_cnt, n);
    chk("pix_count", pix_q.size(), n);
    chk("outstanding_bound", max_out <= 16, 1);
    bad = 0; bad_a = 0;
    foreach (pix_q[i]) begin
      p = pix_q[i];
      if (p.data !== memf(v.base + i) || p.sof !== (i == 0) ||
          p.eol !== ((i % int'(v.w)) == int'(v.w) - 1) || p.eof !== (i == n - 1)) bad++;
    end
    foreach (addr_q[i]) if (addr_q[i] !== v.base + i) bad_a++;
    chk("pix_bad", bad, 0);
    chk("addr_bad", bad_a, 0);
  endtask

  vec_t vecs[5];

  initial begin
    int to, pend, bad;
    vecs[0] = '{w: 4,  h: 2, base: 32'h0000_0100, hold: 0,  exp_n: 8,  exp_stall: 0};
    vecs[1] = '{w: 16, h: 4, base: 32'h0000_2000, hold: 50, exp_n: 64, exp_stall: 16};
    vecs[2] = '{w: 0,  h: 5, base: 32'h0000_0700, hold: 0,  exp_n: 0,  exp_stall: 0};
    vecs[3] = '{w: 3,  h: 1, base: 32'hFFFF_FFFE, hold: 0,  exp_n: 3,  exp_stall: 0};
    vecs[4] = '{w: 1,  h: 1, base: 32'h0000_0042, hold: 0,  exp_n: 1,  exp_stall: 0};

    reset = 1'b0; start = 1'b0; flush = 1'b0; frameAddress = '0; width = '0; height = '0;
    bus.readReady = 1'b1; bus.pixelReady = 1'b1;
    #22;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rv", bus.readValid, 0);
    chk("rst_pv", bus.pixelValid, 0);
    @(posedge clock); #1;
    reset = 1'b1;

`ifdef FRAME_READER_LOOP_EN
    run_frame(vecs[2]);
    clr();
    kick(12'd2, 12'd2, 32'h0000_0500);
    to = 0;
    while (pop_cnt < 12 && to < 500) begin @(negedge clock); #1; to++; end
    @(posedge clock); #1;
    bus.pixelReady = 1'b0;
    @(negedge clock); #1;
    chk("loop_pops", pop_cnt, 12);
    chk("loop_done_count", done_cnt, 3);
    chk("loop_busy", busy, 1);
    bad = 0;
    foreach (pix_q[i])
      if (pix_q[i].data !== memf(32'h500 + (i % 4)) || pix_q[i].eof !== ((i % 4) == 3) ||
          pix_q[i].sof !== ((i % 4) == 0)) bad++;
    chk("loop_pix_bad", bad, 0);
    @(posedge clock); #1; flush = 1'b1;
    @(posedge clock); #1; flush = 1'b0;
    to = 0;
    while (busy && to < 100) begin @(negedge clock); #1; to++; end
    chk("loop_flush_idle", ready, 1);
    chk("loop_flush_no_done", done_cnt, 3);
    bus.pixelReady = 1'b1;
`else
    foreach (vecs[i]) run_frame(vecs[i]);

    // Flush mid-frame with several reads still in flight.
    clr();
    lat = 3;
    kick(12'd8, 12'd2, 32'h0000_0300);
    to = 0;
    while (pop_cnt < 5 && to < 200) begin @(negedge clock); #1; to++; end
    chk("flush_reach5", pop_cnt, 5);
    pend = pending();
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    chk("flush_inflight_nz", pend != 0, 1);
    @(negedge clock); #1;
    chk("flush_pv_drop", bus.pixelValid, 0);
    chk("flush_rv_drop", bus.readValid, 0);
    chk("flush_busy", busy, 1);
    to = 0; bad = 0;
    while (busy && to < 100) begin
      if (bus.pixelValid) bad++;
      @(negedge clock); #1; to++;
    end
    chk("flush_exit", busy, 0);
    chk("flush_pending_at_exit", pending(), 0);
    chk("flush_pv_during", bad, 0);
    chk("flush_no_done", done_cnt, 0);
    chk("flush_ready", ready, 1);
    lat = 2;
    run_frame('{w: 2, h: 1, base: 32'h0000_0040, hold: 0, exp_n: 2, exp_stall: 0});

    // Asynchronous reset in the middle of a frame.
    clr();
    kick(12'd16, 12'd4, 32'h0000_0800);
    repeat (6) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_ready", ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_rv", bus.readValid, 0);
    chk("arst_pv", bus.pixelValid, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock); #1;
    chk("arst_addr_zero", bus.readAddress, 0);
    chk("arst_sof", bus.pixelSof, 1);
    chk("arst_idle", ready, 1);
    run_frame(vecs[0]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Bus master that reads a completed frame of 24-bit pixels from memory and emits it as a raster-ordered pixel stream with valid/ready handshake.
- Reader counterpart to the ray tracer's pixel writes: consumes the frame buffer at frameAddress for display or readback.
- Uses in-order read requests with a credit scheme that bounds outstanding reads by free FIFO space.

Parameters:
- DATA_WIDTH, 24, pixel/read-data width.
- ADDRESS_WIDTH, 32, bus address width; word-addressed, one pixel per word.
- FIFO_DEPTH, 16, response buffer entries; power of two, ≥2.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame start pulse; honoured only when ready=1.
- flush  in  1  abort current frame.
- frameAddress  in  ADDRESS_WIDTH  base address of pixel 0; latched on start.
- width  in  12  pixels per line; latched on start.
- height  in  12  lines per frame; latched on start.
- ready  out  1  idle and able to accept start.
- busy  out  1  frame in progress, including the flush drain.
- done  out  1  one-cycle pulse when a frame completes.
- readAddress  out  ADDRESS_WIDTH  request address.
- readValid  out  1  request valid.
- readReady  in  1  request accepted when readValid and readReady are both 1.
- readData  in  DATA_WIDTH  response data; responses return in order.
- readDataValid  in  1  response strobe; no backpressure.
- pixelData  out  DATA_WIDTH  stream pixel.
- pixelValid  out  1  stream valid.
- pixelReady  in  1  stream ready.
- pixelSof  out  1  qualifies the first pixel of the frame.
- pixelEol  out  1  qualifies the last pixel of each line.
- pixelEof  out  1  qualifies the last pixel of the frame.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; ready=1.
  - busy, done, readValid and pixelValid are 0.
  - All counters and the FIFO are cleared.
- States: IDLE, FETCH, FLUSH.
- IDLE:
  - On start && ready, latch the inputs and set total=width*height (24-bit).
  - If total==0: pulse done the next cycle and stay in IDLE.
  - Otherwise go to FETCH: ready=0, busy=1.
- FETCH, request side:
  - readAddress = base + reqIndex.
  - readValid=1 while reqIndex<total and inFlight+fifoCount<FIFO_DEPTH.
  - The first request is asserted on the cycle after start.
  - Each accepted request increments reqIndex and inFlight.
  - readAddress and readValid hold stable until accepted.
- FETCH, response side:
  - Each readDataValid writes the FIFO and decrements inFlight.
  - A simultaneous accept and response leaves inFlight unchanged.
  - Because of the credit scheme, the FIFO can never overflow.
- FETCH, stream side:
  - pixelValid = FIFO not empty; pixelData = FIFO head.
  - Pop on pixelValid && pixelReady. The FIFO is combinational-read, so a response appears on the stream the cycle after it is written.
  - Output counters x and y advance on each pop.
  - pixelSof when x==0 && y==0.
  - pixelEol when x==width-1.
  - pixelEof when the pixel is the last one.
  - When x wraps to 0, y increments.
- Completion: on the pop of the pixelEof pixel, pulse done and return to IDLE in the same transition; ready=1 and busy=0 on the next cycle.
- flush in FETCH:
  - Deassert readValid and pixelValid immediately and discard FIFO contents.
  - Go to FLUSH; stay there until inFlight==0, dropping arriving responses.
  - Then go to IDLE. done is not pulsed.
- flush in IDLE has no effect. start outside IDLE is ignored.
- Address arithmetic wraps modulo 2^ADDRESS_WIDTH.

Optional Feature:
- Macro FRAME_READER_LOOP_EN.
- Defined:
  - After the pixelEof pop, done still pulses, but the block restarts at pixel 0 with the latched parameters and stays in FETCH.
  - Requests for the next frame may begin as soon as credits allow.
  - Only flush returns the block to IDLE.
  - Zero-size frames still return to IDLE.
- Undefined: single-shot behaviour as specified above.

Decomposition:
- Shared package ray_pkg:
  - pixel_t (DATA_WIDTH-bit logic)
  - reader_state_t enum {IDLE, FETCH, FLUSH}
  - DIM_WIDTH=12
- Sub-module pixel_fifo:
  - Synchronous FIFO with parameters DATA_WIDTH and FIFO_DEPTH.
  - Ports: push, pop, clear, count, empty, full, head.
  - Reset is asynchronous and active-low.

Test Plan:
- Basic frame: width=4, height=2, frameAddress=0x100, memory with 2-cycle latency, pixelReady=1.
  - Requests go to 0x100..0x107.
  - 8 pixels are emitted in order.
  - pixelEol on pixels 3 and 7; pixelSof on pixel 0; pixelEof on pixel 7.
  - One done pulse, then ready=1.
- Backpressure: width=16, height=4, pixelReady=0 for 50 cycles.
  - At most FIFO_DEPTH reads are outstanding or buffered.
  - No data is lost; all 64 pixels match memory contents after release.
- Zero size: width=0, height=5.
  - No readValid ever.
  - done pulses exactly one cycle after start.
- Flush: flush after 5 pixels with 3 reads in flight.
  - pixelValid drops the next cycle; busy stays 1 until the 3 responses arrive.
  - No done pulse.
  - A new start with width=2, height=1 then yields exactly 2 correct pixels.
- Reset mid-frame: assert reset=0 during FETCH.
  - All outputs return to their reset values asynchronously.
  - Counters are zero after release.
- Loop (FRAME_READER_LOOP_EN): width=2, height=2.
  - Pixels 0..3 repeat for 3 frames, with done pulsing at each pixelEof.
  - flush returns the block to IDLE.
